alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL provide clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-002 The block SHALL provide reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL provide req0, input, 1 bit: requester 0 wants an operation.
REQ-004 The block SHALL provide a0, b0, input, 32 bits each: requester 0 operands.
REQ-005 The block SHALL provide op0, input, 3 bits: requester 0 ALU opcode.
REQ-006 The block SHALL provide req1, a1, b1 and op1 with the same widths and meaning for requester 1.
REQ-007 The block SHALL provide gnt0 and gnt1, output, 1 bit each: registered one-cycle accept pulses.
REQ-008 The block SHALL provide res, output, 32 bits: registered ALU result.
REQ-009 The block SHALL provide res_valid, output, 1 bit: one-cycle pulse marking res valid.
REQ-010 The block SHALL provide res_id, output, 1 bit: requester owning res.
REQ-011 The block SHALL provide busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The block SHALL share one internal 32-bit ALU between two requesters using an FSM with states IDLE and EXEC.
REQ-013 In IDLE with at least one req high at a rising edge, the block SHALL select a winner, latch its a, b and op plus the winner id, pulse the matching gnt for the next cycle, and enter EXEC.
REQ-014 In IDLE with no req high, the block SHALL remain in IDLE with both gnt low.
REQ-015 With exactly one req high, that requester SHALL win.
REQ-016 With both req high, the winner SHALL be the requester not granted last, per a last_id register.
REQ-017 In EXEC, the block SHALL ignore req inputs, register res from the latched operands, set res_id to the latched id, pulse res_valid for the next cycle, and return to IDLE.
REQ-018 Latency SHALL be 2 cycles from the accepting edge to res_valid high, and the peak rate SHALL be one operation per 2 cycles.
REQ-019 Requesters SHALL hold req and operands stable until they see gnt, and SHALL drop req on the edge ending the gnt cycle; a req still high in the next IDLE cycle is a new request.
REQ-020 gnt0 and gnt1 SHALL never be high together, and SHALL only be high in the EXEC cycle.
REQ-021 res SHALL hold its value between res_valid pulses.
REQ-022 ALU op 000 SHALL compute A+B modulo 2^32.
REQ-023 ALU op 001 SHALL compute A-B modulo 2^32.
REQ-024 ALU op 010 SHALL compute A AND B.
REQ-025 ALU op 011 SHALL compute A OR B.
REQ-026 ALU op 100 SHALL compute a logical right shift of A by the full 32-bit B; B>=32 SHALL give 0.
REQ-027 ALU ops 101, 110 and 111 SHALL compute an arithmetic right shift of A by the full 32-bit B; B>=32 SHALL give all bits equal to A[31].

Reset
REQ-028 Reset SHALL force state=IDLE, gnt0=0, gnt1=0, res_valid=0, res=0, res_id=0, last_id=1 so that requester 0 wins the first tie, and busy=0.
REQ-029 Reset asserted in EXEC SHALL abort the operation: no res_valid pulse, and res stays 0 after the reset cycle.
REQ-030 Reset SHALL take priority over all other events on the same edge.

Verification
REQ-031 Single request: req0=1, a0=5, b0=3, op0=000 -> gnt0 pulse 1 cycle later, then res=8, res_valid=1, res_id=0 2 cycles after acceptance.
REQ-032 Tie after reset: req0 and req1 both high, op0=001 with a0=3, b0=5; op1=010 with a1=0xF0F0, b1=0xFF00 -> first res=0xFFFFFFFE with id 0, then res=0xF000 with id 1; gnt pulses spaced 2 cycles apart.
REQ-033 Shifts: op=100, A=0x80000000, B=4 -> 0x08000000; op=101 with the same operands -> 0xF8000000; op=101, B=40 -> 0xFFFFFFFF; op=100, B=32 -> 0.
REQ-034 Fairness: both req held continuously for 8 operations -> grants strictly alternate, 4 each, busy high except single IDLE cycles.
REQ-035 Reset mid-operation: reset in the EXEC cycle -> no res_valid pulse, all outputs 0, next request is served normally with requester 0 winning a tie.
REQ-036 Idle hold: no req for 10 cycles after a result -> busy=0, gnt0=gnt1=0, res unchanged, res_valid=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared 32-bit ALU.
// Each accepted operation takes one IDLE cycle plus one EXEC cycle.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [2:0]  op0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] res,
  output logic        res_valid,
  output logic        res_id,
  output logic        busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, b_reg;
  logic [2:0]  op_reg;
  logic        id_reg;
  logic        last_id_reg;

  logic        accept;
  logic        winner;
  logic [31:0] alu_out;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    winner     = (req0 && req1) ? ~last_id_reg : req1;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift amounts use the whole 32-bit B, so large counts saturate.
  always_comb begin
    alu_out = '0;
    case (op_reg)
      3'b000:  alu_out = a_reg + b_reg;
      3'b001:  alu_out = a_reg - b_reg;
      3'b010:  alu_out = a_reg & b_reg;
      3'b011:  alu_out = a_reg | b_reg;
      3'b100:  alu_out = (b_reg > 32'd31) ? 32'd0 : (a_reg >> b_reg[4:0]);
      default: alu_out = (b_reg > 32'd31) ? {32{a_reg[31]}}
                                          : $unsigned($signed(a_reg) >>> b_reg[4:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      res_valid   <= 1'b0;
      res         <= '0;
      res_id      <= 1'b0;
      last_id_reg <= 1'b1;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      id_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt0      <= accept && !winner;
      gnt1      <= accept && winner;
      res_valid <= (state_reg == EXEC);
      if (accept) begin
        a_reg       <= winner ? a1 : a0;
        b_reg       <= winner ? b1 : b0;
        op_reg      <= winner ? op1 : op0;
        id_reg      <= winner;
        last_id_reg <= winner;
      end
      if (state_reg == EXEC) begin
        res    <= alu_out;
        res_id <= id_reg;
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks of alu_arbiter against a transaction-timing model:
// an accepted op owns the ALU for two edges, grants in the first window, results in the second.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1, res_valid, res_id, busy;
  logic [31:0] res;

  logic        tr_req [2];
  logic [31:0] tr_a   [2];
  logic [31:0] tr_b   [2];
  logic [2:0]  tr_op  [2];
  bit          drop   [2];
  bit          hold;
  bit          rand_en;

  assign req0 = tr_req[0];
  assign a0   = tr_a[0];
  assign b0   = tr_b[0];
  assign op0  = tr_op[0];
  assign req1 = tr_req[1];
  assign a1   = tr_a[1];
  assign b1   = tr_b[1];
  assign op1  = tr_op[1];

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .res(res), .res_valid(res_valid),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model state: edge counter and the windows in which events are due.
  int          n         = 0;
  int          free_edge = 0;
  int          gnt_win   = -1;
  bit          gnt_who   = 1'b0;
  int          res_win   = -1;
  logic [31:0] pend_res  = '0;
  bit          pend_id   = 1'b0;
  logic [31:0] exp_res   = '0;
  bit          exp_id    = 1'b0;
  bit          last      = 1'b1;
  int          cnt0, cnt1;

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [63:0] ext;
    int sh;
    case (op)
      3'd0: return a + b;
      3'd1: return a + ~b + 32'd1;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (b >= 32) ? 32'd0 : a >> b;
      default: begin
        ext = {{32{a[31]}}, a};
        sh  = (b >= 32) ? 32 : int'(b);
        ext = ext >> sh;
        return ext[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, n);
    end
  endtask

  task automatic tick();
    bit w;
    @(posedge clk);
    n++;
    if (reset) begin
      gnt_win   = -1;
      res_win   = -1;
      exp_res   = '0;
      exp_id    = 1'b0;
      last      = 1'b1;
      free_edge = n + 1;
    end else begin
      if (res_win == n) begin
        exp_res = pend_res;
        exp_id  = pend_id;
      end
      if (n >= free_edge && (tr_req[0] || tr_req[1])) begin
        w         = (tr_req[0] && tr_req[1]) ? !last : tr_req[1];
        last      = w;
        gnt_win   = n;
        gnt_who   = w;
        pend_res  = ref_alu(tr_a[w], tr_b[w], tr_op[w]);
        pend_id   = w;
        res_win   = n + 1;
        free_edge = n + 2;
      end
    end
    #1;
    chk("gnt0", gnt0, (gnt_win == n) && !gnt_who);
    chk("gnt1", gnt1, (gnt_win == n) && gnt_who);
    chk("busy", busy, gnt_win == n);
    chk("res_valid", res_valid, res_win == n);
    chk("res", res, exp_res);
    chk("res_id", res_id, exp_id);
    $display("edge %0d req=%b%b gnt=%b%b busy=%b valid=%b res=%08h id=%b",
             n, tr_req[1], tr_req[0], gnt1, gnt0, busy, res_valid, res, res_id);
    // Requesters hold through the grant cycle and drop on the edge that ends it.
    for (int i = 0; i < 2; i++) begin
      if (drop[i]) begin
        tr_req[i] = 1'b0;
        drop[i]   = 1'b0;
      end
      if (!hold && gnt_win == n && gnt_who == i[0]) drop[i] = 1'b1;
      if (rand_en && !tr_req[i] && $urandom_range(0, 2) == 0) begin
        tr_req[i] = 1'b1;
        tr_a[i]   = $urandom_range(0, 3) == 0 ? 32'h8000_0000 | $urandom : $urandom;
        tr_b[i]   = $urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
        tr_op[i]  = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    tr_req[i] = 1'b1;
    tr_a[i]   = a;
    tr_b[i]   = b;
    tr_op[i]  = op;
  endtask

  task automatic single_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] expv, input string tag);
    set_req(0, a, b, op);
    tick();
    tick();
    chk(tag, res, expv);
    tick();
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    hold    = 1'b0;
    rand_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tr_req[i] = 1'b0;
      tr_a[i]   = '0;
      tr_b[i]   = '0;
      tr_op[i]  = '0;
      drop[i]   = 1'b0;
    end

    repeat (3) tick();
    chk("rst_res", res, 32'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Single request: 5 + 3.
    set_req(0, 32'd5, 32'd3, 3'b000);
    tick();
    chk("single_gnt0", gnt0, 1'b1);
    tick();
    chk("single_res", res, 32'd8);
    chk("single_valid", res_valid, 1'b1);
    chk("single_id", res_id, 1'b0);
    tick();
    tick();

    // Tie right after reset: requester 0 first, requester 1 two cycles later.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 32'd3, 32'd5, 3'b001);
    set_req(1, 32'h0000_F0F0, 32'h0000_FF00, 3'b010);
    tick();
    chk("tie_gnt0", gnt0, 1'b1);
    tick();
    chk("tie_res0", res, 32'hFFFF_FFFE);
    chk("tie_id0", res_id, 1'b0);
    tick();
    chk("tie_gnt1", gnt1, 1'b1);
    tick();
    chk("tie_res1", res, 32'h0000_F000);
    chk("tie_id1", res_id, 1'b1);
    tick();
    tick();

    // Shift boundaries.
    single_op(32'h8000_0000, 32'd4,  3'b100, 32'h0800_0000, "srl4");
    single_op(32'h8000_0000, 32'd4,  3'b101, 32'hF800_0000, "sra4");
    single_op(32'h8000_0000, 32'd40, 3'b101, 32'hFFFF_FFFF, "sra40");
    single_op(32'h8000_0000, 32'd32, 3'b100, 32'h0000_0000, "srl32");
    single_op(32'h8000_0000, 32'd33, 3'b111, 32'hFFFF_FFFF, "sra33_op7");

    // Fairness: both requests held for 8 operations.
    hold = 1'b1;
    set_req(0, 32'd100, 32'd1, 3'b000);
    set_req(1, 32'd100, 32'd1, 3'b001);
    cnt0 = 0;
    cnt1 = 0;
    repeat (16) begin
      tick();
      cnt0 += int'(gnt0);
      cnt1 += int'(gnt1);
    end
    chk("fair_cnt0", cnt0, 4);
    chk("fair_cnt1", cnt1, 4);
    hold      = 1'b0;
    tr_req[0] = 1'b0;
    tr_req[1] = 1'b0;
    tick();
    tick();

    // Reset during EXEC aborts the operation.
    set_req(0, 32'd1, 32'd1, 3'b000);
    set_req(1, 32'd2, 32'd2, 3'b000);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_valid", res_valid, 1'b0);
    chk("abort_res", res, 32'd0);
    chk("abort_gnt", gnt0 | gnt1, 1'b0);
    reset   = 1'b0;
    drop[0] = 1'b0;
    drop[1] = 1'b0;
    set_req(0, 32'd7, 32'd2, 3'b000);
    set_req(1, 32'h10, 32'h01, 3'b011);
    tick();
    chk("post_abort_gnt0", gnt0, 1'b1);
    tick();
    chk("post_abort_res0", res, 32'd9);
    tick();
    tick();
    chk("post_abort_res1", res, 32'h11);

    // Idle hold for 10 cycles.
    repeat (10) tick();
    chk("idle_res", res, 32'h11);
    chk("idle_busy", busy, 1'b0);

    // Random traffic with occasional resets.
    rand_en = 1'b1;
    repeat (400) begin
      reset = ($urandom_range(0, 60) == 0);
      tick();
    end
    reset   = 1'b0;
    rand_en = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
